// File: rtl/fwd_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Bundles the signals between the pipeline and the forwarding/hazard controller.
//   master : pipeline side. It drives the ID-stage fields, branch_taken and
//            mdu_done, and it receives the stall, flush, bubble and forwarding
//            controls.
//   slave  : controller side. The directions are the reverse of master.
// Signals:
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
//   id_regwrite, id_memread, id_is_mdu : the instruction in ID
//   branch_taken : a taken branch resolves in EX this cycle
//   mdu_done     : the multi-cycle unit finishes this cycle
//   stall_if, stall_id, flush_id, bubble_ex : pipeline control
//   fwd_a_sel, fwd_b_sel : EX operand mux selects (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   stall_cnt            : saturating count of stalled cycles
// -----------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_is_mdu;
  logic              branch_taken;
  logic              mdu_done;
  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              bubble_ex;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, id_is_mdu, branch_taken, mdu_done,
    input  stall_if, stall_id, flush_id, bubble_ex, fwd_a_sel, fwd_b_sel,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, id_is_mdu, branch_taken, mdu_done,
    output stall_if, stall_id, flush_id, bubble_ex, fwd_a_sel, fwd_b_sel,
           stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and hazard controller for a classic five-stage pipeline.
// The controller keeps shadow copies {rd, we, load} of the EX, MEM and WB
// stages. It uses these copies to detect load-use hazards, to hold the
// pipeline while a multi-cycle mul/div unit is busy, to flush on taken
// branches, and to produce registered forwarding selects for the EX stage.
// Ports:
//   clk   : clock. All state updates happen on its rising edge.
//   rst_n : asynchronous, active-low reset.
//   bus   : fwd_hazard_ctrl_if.slave, which carries the ID fields and the
//           control outputs.
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fwd_hazard_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {RUN, LDSTALL, MDU_BUSY} state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } slot_t;

  localparam int EX  = 0;
  localparam int MEM = 1;

  state_t            state_q, state_d;
  slot_t             pipe_q [3];   // [0]=EX, [1]=MEM, [2]=WB
  slot_t             ex_d;
  logic [1:0]        fwd_q [2];
  logic [1:0]        fwd_d [2];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [REG_AW-1:0] src [2];
  logic              src_used [2];
  logic [1:0]        lu_hit;
  logic              load_use;
  logic              stall_c, flush_c, bubble_c;
  logic              id_adv;

  assign src[0]      = bus.id_rs;
  assign src[1]      = bus.id_rt;
  assign src_used[0] = bus.id_uses_rs;
  assign src_used[1] = bus.id_uses_rt;

  // The forwarding priority is computed against the slots as they are now.
  // The current EX slot becomes EX/MEM when the ID instruction reaches EX,
  // and the current MEM slot becomes MEM/WB at that point.
  function automatic logic [1:0] fwd_sel(input logic used,
                                         input logic [REG_AW-1:0] s,
                                         input slot_t ex_s,
                                         input slot_t mem_s);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (s != '0)) begin
      if (ex_s.we && (ex_s.rd == s))
        sel = 2'b01;
      else if (mem_s.we && (mem_s.rd == s))
        sel = 2'b10;
    end
    return sel;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign lu_hit[gi] = src_used[gi] && (src[gi] == pipe_q[EX].rd);
      // A bubble entering EX must not carry a stale forwarding select.
      assign fwd_d[gi]  = id_adv ? fwd_sel(src_used[gi], src[gi],
                                           pipe_q[EX], pipe_q[MEM])
                                 : 2'b00;
    end
  endgenerate

  assign load_use = bus.id_valid && pipe_q[EX].load &&
                    (pipe_q[EX].rd != '0) && (|lu_hit);

  // Next-state and control logic.
  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    case (state_q)
      // LDSTALL lasts one cycle. A bubble sits in EX during that cycle, so
      // re-evaluating the hazard here can never see a second load-use match.
      RUN, LDSTALL: begin
        state_d = RUN;
        if (bus.branch_taken) begin
          // The flush cancels any hazard or MDU launch from the killed ID
          // instruction.
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = LDSTALL;
        end else if (bus.id_valid && bus.id_is_mdu) begin
          state_d = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        if (bus.mdu_done) begin
          state_d = RUN;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
        // A branch flushes ID but the MDU operation stays in progress.
        if (bus.branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign id_adv = bus.id_valid && !stall_c && !flush_c;

  always_comb begin
    ex_d = '0;
    if (id_adv) begin
      ex_d.rd   = bus.id_rd;
      ex_d.we   = bus.id_regwrite;
      ex_d.load = bus.id_memread;
    end
  end

  assign cnt_d = (stall_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe_q[i] <= '0;
      fwd_q[0] <= 2'b00;
      fwd_q[1] <= 2'b00;
      cnt_q    <= '0;
    end else begin
      pipe_q[0] <= ex_d;
      for (int i = 1; i < 3; i++) pipe_q[i] <= pipe_q[i-1];
      fwd_q[0] <= fwd_d[0];
      fwd_q[1] <= fwd_d[1];
      cnt_q    <= cnt_d;
    end
  end

  // The combinational controls are gated so that they read 0 during reset,
  // even when branch_taken is high.
  assign bus.stall_if  = rst_n & stall_c;
  assign bus.stall_id  = rst_n & stall_c;
  assign bus.flush_id  = rst_n & flush_c;
  assign bus.bubble_ex = rst_n & bubble_c;
  assign bus.fwd_a_sel = fwd_q[0];
  assign bus.fwd_b_sel = fwd_q[1];
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       rstn;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mdu;
    logic       br;
    logic       done;
  } stim_t;

  typedef struct packed {
    logic        sif;
    logic        sid;
    logic        fl;
    logic        bub;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  obs_t sb_q [$];

  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hif ();

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(input logic rstn, input logic valid,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt,
                              input logic [4:0] rd, input logic rw,
                              input logic mr, input logic mdu,
                              input logic br, input logic done);
    stim_t s;
    s = {rstn, valid, rs, rt, urs, urt, rd, rw, mr, mdu, br, done};
    return s;
  endfunction

  function automatic obs_t E(input logic stall, input logic fl,
                             input logic bub, input logic [1:0] fa,
                             input logic [1:0] fb);
    obs_t e;
    e = {stall, stall, fl, bub, fa, fb, 16'd0};
    return e;
  endfunction

  function automatic stim_t NOP();
    return S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {hif.stall_if, hif.stall_id, hif.flush_id, hif.bubble_ex,
         hif.fwd_a_sel, hif.fwd_b_sel, hif.stall_cnt};
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("stall_if=%b stall_id=%b flush=%b bubble=%b fwd_a=%b fwd_b=%b cnt=%0d",
                     o.sif, o.sid, o.fl, o.bub, o.fa, o.fb, o.cnt);
  endfunction

  // Drives one cycle of stimulus just after the rising edge and pushes the
  // expected outputs for that cycle. stall_cnt shows the number of stall
  // cycles that came before this one.
  task automatic apply_row(input stim_t s, input obs_t e);
    @(posedge clk);
    #1;
    rst_n            = s.rstn;
    hif.id_valid     = s.valid;
    hif.id_rs        = s.rs;
    hif.id_rt        = s.rt;
    hif.id_uses_rs   = s.urs;
    hif.id_uses_rt   = s.urt;
    hif.id_rd        = s.rd;
    hif.id_regwrite  = s.rw;
    hif.id_memread   = s.mr;
    hif.id_is_mdu    = s.mdu;
    hif.branch_taken = s.br;
    hif.mdu_done     = s.done;
    if (!s.rstn) exp_cnt = 16'd0;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    if (s.rstn && e.sid && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(0, 1, 3, 0, 1, 0, 0, 1, 0, 1, 1, 1)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    foreach (st[i]) begin
      apply_row(st[i], ex[i]);
      got = observe(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset row %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end else $display("reset row %0d ok: %s", i, fmt(got));
    end
  endtask

  task automatic test_alu_forward();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b01, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    foreach (st[i]) begin
      apply_row(st[i], ex[i]);
      got = observe(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL alu_forward row %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end else $display("alu_forward row %0d ok: %s", i, fmt(got));
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 3, 6, 1, 1, 8, 1, 0, 0, 0, 0)); ex.push_back(E(1, 0, 1, 2'b00, 2'b00));
    st.push_back(S(1, 1, 3, 6, 1, 1, 8, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b10, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    foreach (st[i]) begin
      apply_row(st[i], ex[i]);
      got = observe(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use row %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end else $display("load_use row %0d ok: %s", i, fmt(got));
    end
  endtask

  task automatic test_mdu();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 1, 1, 2, 1, 1, 9, 1, 0, 1, 0, 0));       ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    for (int k = 0; k < 4; k++) begin
      st.push_back(S(1, 1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 0));  ex.push_back(E(1, 0, 1, 2'b00, 2'b00));
    end
    st.push_back(S(1, 1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 1));    ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));       ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                       ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    foreach (st[i]) begin
      apply_row(st[i], ex[i]);
      got = observe(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mdu row %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end else $display("mdu row %0d ok: %s", i, fmt(got));
    end
  endtask

  task automatic test_branch_flush();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 3, 6, 1, 1, 8, 1, 0, 0, 1, 0)); ex.push_back(E(0, 1, 1, 2'b00, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 1, 2, 1, 1, 9, 1, 0, 1, 1, 0)); ex.push_back(E(0, 1, 1, 2'b00, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    foreach (st[i]) begin
      apply_row(st[i], ex[i]);
      got = observe(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL branch_flush row %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end else $display("branch_flush row %0d ok: %s", i, fmt(got));
    end
  endtask

  task automatic test_mdu_branch();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 1, 1, 2, 1, 1, 9, 1, 0, 1, 0, 0));    ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 10, 11, 1, 1, 12, 1, 0, 0, 1, 0)); ex.push_back(E(1, 1, 1, 2'b00, 2'b00));
    st.push_back(S(1, 1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 0)); ex.push_back(E(1, 0, 1, 2'b00, 2'b00));
    st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));    ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                    ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    foreach (st[i]) begin
      apply_row(st[i], ex[i]);
      got = observe(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mdu_branch row %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end else $display("mdu_branch row %0d ok: %s", i, fmt(got));
    end
  endtask

  task automatic test_zero_and_priority();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 7, 7, 0, 1, 8, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b01));
    st.push_back(NOP());                                 ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    foreach (st[i]) begin
      apply_row(st[i], ex[i]);
      got = observe(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL zero_priority row %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end else $display("zero_priority row %0d ok: %s", i, fmt(got));
    end
  endtask

  task automatic test_reset_mid_mdu();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 1, 1, 2, 1, 1, 9, 1, 0, 1, 0, 0));    ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 0)); ex.push_back(E(1, 0, 1, 2'b00, 2'b00));
    st.push_back(S(0, 1, 10, 11, 1, 1, 12, 1, 0, 0, 1, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 1, 10, 11, 1, 1, 12, 1, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));    ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    st.push_back(NOP());                                    ex.push_back(E(0, 0, 0, 2'b00, 2'b00));
    foreach (st[i]) begin
      apply_row(st[i], ex[i]);
      got = observe(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_mdu row %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end else $display("reset_mid_mdu row %0d ok: %s", i, fmt(got));
    end
  endtask

  initial begin
    hif.id_valid     = 1'b0;
    hif.id_rs        = '0;
    hif.id_rt        = '0;
    hif.id_uses_rs   = 1'b0;
    hif.id_uses_rt   = 1'b0;
    hif.id_rd        = '0;
    hif.id_regwrite  = 1'b0;
    hif.id_memread   = 1'b0;
    hif.id_is_mdu    = 1'b0;
    hif.branch_taken = 1'b0;
    hif.mdu_done     = 1'b0;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_mdu();
    test_branch_flush();
    test_mdu_branch();
    test_zero_and_priority();
    test_reset_mid_mdu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
